// File: rtl/button_debouncer.sv
// Push-button debouncer: multi-flop synchronizer feeding a four-state qualifier FSM
// that accepts a new level only after it holds for STABLE_CYCLES synchronized cycles.
module button_debouncer #(
  parameter int unsigned STABLE_CYCLES = 1000000,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_noisy,
  output logic btn_db,
  output logic btn_rise,
  output logic btn_fall,
  output logic busy
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic [1:0] {
    StStableLow,
    StWaitHigh,
    StStableHigh,
    StWaitLow
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            db_d, rise_d, fall_d;

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync_q;

  assign sync_q = sync_chain[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_chain <= '0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], btn_noisy};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StStableLow;
      cnt_q    <= '0;
      btn_db   <= 1'b0;
      btn_rise <= 1'b0;
      btn_fall <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      btn_db   <= db_d;
      btn_rise <= rise_d;
      btn_fall <= fall_d;
    end
  end

  // An opposing sample always aborts, even when the counter is at its terminal value.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    db_d    = btn_db;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      StStableLow: begin
        cnt_d = '0;
        db_d  = 1'b0;
        if (sync_q) begin
          state_d = StWaitHigh;
          cnt_d   = CntOne;
        end
      end
      StWaitHigh: begin
        if (!sync_q) begin
          state_d = StStableLow;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StStableHigh;
          cnt_d   = '0;
          db_d    = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StStableHigh: begin
        cnt_d = '0;
        db_d  = 1'b1;
        if (!sync_q) begin
          state_d = StWaitLow;
          cnt_d   = CntOne;
        end
      end
      StWaitLow: begin
        if (sync_q) begin
          state_d = StStableHigh;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StStableLow;
          cnt_d   = '0;
          db_d    = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = StStableLow;
        cnt_d   = '0;
        db_d    = 1'b0;
      end
    endcase
  end

  always_comb begin
    busy = (state_q == StWaitHigh) || (state_q == StWaitLow);
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: fixed vector table, hand-built bounce/reset sequences and
// random stimulus, all checked against a run-length reference model.
module tb_button_debouncer;

  localparam int unsigned SC = 4;
  localparam int unsigned SS = 2;

  logic clk = 1'b0;
  logic rst, btn_noisy, btn_db, btn_rise, btn_fall, busy;

  always #5 clk = ~clk;

  button_debouncer #(
    .STABLE_CYCLES(SC),
    .SYNC_STAGES  (SS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_noisy(btn_noisy),
    .btn_db   (btn_db),
    .btn_rise (btn_rise),
    .btn_fall (btn_fall),
    .busy     (busy)
  );

  int total = 0;
  int bad   = 0;
  int rises = 0;
  int falls = 0;

  // Reference: the level seen by the qualifier lags the pin by two samples; the output
  // flips once SC consecutive seen samples disagree with it.
  logic m_d1, m_d2, m_db, m_rise, m_fall;
  int   m_run;

  task automatic model_edge(input logic r, input logic b);
    if (r) begin
      m_d1 = 1'b0; m_d2 = 1'b0; m_db = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_run = 0;
    end else begin
      logic s;
      s      = m_d2;
      m_d2   = m_d1;
      m_d1   = b;
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (s != m_db) begin
        m_run++;
        if (m_run == int'(SC)) begin
          m_db   = s;
          m_rise = s;
          m_fall = ~s;
          m_run  = 0;
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input logic r, input logic b);
    rst       = r;
    btn_noisy = b;
    @(posedge clk);
    model_edge(r, b);
    #1;
    check("model {db,rise,fall,busy}", int'({btn_db, btn_rise, btn_fall, busy}),
          int'({m_db, m_rise, m_fall, m_run > 0}));
    check("rise_fall_coincident", int'(btn_rise & btn_fall), 0);
    rises += int'(btn_rise);
    falls += int'(btn_fall);
  endtask

  typedef struct {
    logic       r;
    logic       b;
    logic [3:0] exp;  // {db, rise, fall, busy} after the edge
  } vec_t;

  vec_t tbl[$];
  logic [3:0] rise_pat[8];
  int rise_at;
  logic lvl;
  int len;

  initial begin
    rst       = 1'b1;
    btn_noisy = 1'b0;

    // Reset, 20 quiet cycles, then a clean rise first sampled at table offset 22.
    rise_pat = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b1100, 4'b1000, 4'b1000};
    for (int i = 0; i < 2; i++) tbl.push_back('{1'b1, 1'b0, 4'b0000});
    for (int i = 0; i < 20; i++) tbl.push_back('{1'b0, 1'b0, 4'b0000});
    for (int i = 0; i < 8; i++) tbl.push_back('{1'b0, 1'b1, rise_pat[i]});
    foreach (tbl[i]) begin
      tick(tbl[i].r, tbl[i].b);
      check("table vector", int'({btn_db, btn_rise, btn_fall, busy}), int'(tbl[i].exp));
    end

    // Clean fall: one pulse five edges after the first low sample.
    rises = 0; falls = 0; rise_at = -1;
    for (int j = 0; j < 10; j++) begin
      tick(1'b0, 1'b0);
      if (btn_fall) rise_at = j;
    end
    check("fall_latency", rise_at, 5);
    check("fall_count", falls, 1);

    // Short high bounce is rejected.
    rises = 0; falls = 0;
    for (int j = 0; j < 3; j++) tick(1'b0, 1'b1);
    for (int j = 0; j < 12; j++) tick(1'b0, 1'b0);
    check("bounce_pulses", rises + falls, 0);
    check("bounce_state {db,busy}", int'({btn_db, busy}), 0);

    // Go high, then bounce 10 times before settling low: exactly one fall.
    for (int j = 0; j < 10; j++) tick(1'b0, 1'b1);
    check("held_high_db", int'(btn_db), 1);
    rises = 0; falls = 0;
    lvl = 1'b0;
    for (int t = 0; t < 10; t++) begin
      len = $urandom_range(1, 2);
      for (int j = 0; j < len; j++) tick(1'b0, lvl);
      lvl = ~lvl;
    end
    for (int j = 0; j < 12; j++) tick(1'b0, 1'b0);
    check("bounce_fall_count", falls, 1);
    check("bounce_rise_count", rises, 0);

    // Reset mid-qualification with counter at 2, then full requalification.
    for (int j = 0; j < 4; j++) tick(1'b0, 1'b1);
    check("mid_wait_busy", int'(busy), 1);
    tick(1'b1, 1'b1);
    check("mid_reset_outputs", int'({btn_db, btn_rise, btn_fall, busy}), 0);
    rises = 0; rise_at = -1;
    for (int j = 0; j < 8; j++) begin
      tick(1'b0, 1'b1);
      if (btn_rise) rise_at = j;
    end
    check("requal_latency", rise_at, 5);
    check("requal_rise_count", rises, 1);

    // Random runs with occasional resets.
    for (int i = 0; i < 300; i++) begin
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 9);
      for (int j = 0; j < len; j++) tick(($urandom_range(0, 199) == 0), lvl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
